// File: rtl/register_file_v2_if.sv
// Register file access bus: one write port and two asynchronous read ports.
//   Write      write enable, sampled at the rising clock edge
//   WriteAddr  destination register index
//   DataIn     write data
//   ReadAddrA  read port A register index
//   ReadAddrB  read port B register index
//   ReadDataA  contents of register[ReadAddrA]
//   ReadDataB  contents of register[ReadAddrB]
// master: datapath side (drives addresses/data, receives read data)
// slave : register file side
interface register_file_v2_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  Write;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [ADDR_WIDTH-1:0] ReadAddrA;
  logic [ADDR_WIDTH-1:0] ReadAddrB;
  logic [DATA_WIDTH-1:0] ReadDataA;
  logic [DATA_WIDTH-1:0] ReadDataB;

  modport master (
    output Write, WriteAddr, DataIn, ReadAddrA, ReadAddrB,
    input  ReadDataA, ReadDataB
  );

  modport slave (
    input  Write, WriteAddr, DataIn, ReadAddrA, ReadAddrB,
    output ReadDataA, ReadDataB
  );
endinterface

// File: rtl/register_file_v2.sv
// General-purpose register file for the accumulator datapath.
// 2**ADDR_WIDTH registers of DATA_WIDTH bits, one synchronous write port and
// two independent combinational read ports.
// Ports:
//   CLK    system clock, state changes on the rising edge
//   Reset  synchronous active-high reset, clears every register, beats Write
//   bus    register_file_v2_if.slave (write port + read ports A/B)
// Build option:
//   REGFILE_WRITE_BYPASS_EN  when defined, a read port addressing the register
//   being written returns DataIn in the same cycle; otherwise it returns the
//   stored (old) value until the edge.
module register_file_v2 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic                   CLK,
  input logic                   Reset,
  register_file_v2_if.slave     bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      regs <= '{default: '0};
    end else if (bus.Write) begin
      regs[bus.WriteAddr] <= bus.DataIn;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  always_comb begin
    fwd_a = bus.Write && !Reset && (bus.WriteAddr == bus.ReadAddrA);
    fwd_b = bus.Write && !Reset && (bus.WriteAddr == bus.ReadAddrB);
    bus.ReadDataA = fwd_a ? bus.DataIn : regs[bus.ReadAddrA];
    bus.ReadDataB = fwd_b ? bus.DataIn : regs[bus.ReadAddrB];
  end
`else
  always_comb begin
    bus.ReadDataA = regs[bus.ReadAddrA];
    bus.ReadDataB = regs[bus.ReadAddrB];
  end
`endif

endmodule

// File: tb/tb_register_file_v2.sv
// Directed self-checking bench for register_file_v2.
module tb_register_file_v2;

  logic CLK = 1'b0;
  logic Reset;

  int unsigned pass_cnt = 0;
  int unsigned check_cnt = 0;

  register_file_v2_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  register_file_v2 #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic read_ab(input logic [3:0] a, input logic [3:0] b,
                         input logic [15:0] exp_a, input logic [15:0] exp_b,
                         input string tag);
    bus.ReadAddrA = a;
    bus.ReadAddrB = b;
    #1;
    check({tag, "_A"}, bus.ReadDataA, exp_a);
    check({tag, "_B"}, bus.ReadDataB, exp_b);
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
    bus.Write     = 1'b1;
    bus.WriteAddr = addr;
    bus.DataIn    = data;
    tick();
    bus.Write     = 1'b0;
  endtask

  initial begin
    Reset         = 1'b1;
    bus.Write     = 1'b0;
    bus.WriteAddr = '0;
    bus.DataIn    = '0;
    bus.ReadAddrA = '0;
    bus.ReadAddrB = '0;

    // Reset clears everything
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 16; i++)
      read_ab(4'(i), 4'(15 - i), 16'h0000, 16'h0000, "reset");

    // Write i+1 to register i for i = 0..9
    for (int i = 0; i < 10; i++)
      write_reg(4'(i), 16'(i + 1));
    for (int i = 0; i < 9; i++)
      read_ab(4'(i), 4'(i + 1), 16'(i + 1), 16'(i + 2), "wr_seq");
    // Registers never written must still be zero
    read_ab(4'd10, 4'd14, 16'h0000, 16'h0000, "untouched");

    // Write=0 must not change anything
    bus.Write  = 1'b0;
    bus.DataIn = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      bus.WriteAddr = 4'(i);
      tick();
    end
    for (int i = 0; i < 9; i++)
      read_ab(4'(i), 4'(i + 1), 16'(i + 1), 16'(i + 2), "no_wr");

    // Extremes at address boundaries, both ports
    write_reg(4'd15, 16'hFFFF);
    write_reg(4'd0,  16'hA5A5);
    read_ab(4'd15, 4'd0, 16'hFFFF, 16'hA5A5, "edge");
    read_ab(4'd0, 4'd15, 16'hA5A5, 16'hFFFF, "edge_swap");
    read_ab(4'd15, 4'd15, 16'hFFFF, 16'hFFFF, "same_addr");

    // Reset wins over a simultaneous write
    Reset         = 1'b1;
    bus.Write     = 1'b1;
    bus.WriteAddr = 4'd3;
    bus.DataIn    = 16'h1234;
    tick();
    Reset     = 1'b0;
    bus.Write = 1'b0;
    read_ab(4'd3, 4'd15, 16'h0000, 16'h0000, "rst_prio");
    read_ab(4'd0, 4'd9, 16'h0000, 16'h0000, "rst_all");

    // Read-during-write on port A; port B reads a different register
    write_reg(4'd5, 16'h0006);
    write_reg(4'd6, 16'h0077);
    bus.Write     = 1'b1;
    bus.WriteAddr = 4'd5;
    bus.DataIn    = 16'h00FF;
    bus.ReadAddrA = 4'd5;
    bus.ReadAddrB = 4'd6;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_before_A", bus.ReadDataA, 16'h00FF);
`else
    check("rdw_before_A", bus.ReadDataA, 16'h0006);
`endif
    check("rdw_before_B", bus.ReadDataB, 16'h0077);
    tick();
    bus.Write = 1'b0;
    check("rdw_after_A", bus.ReadDataA, 16'h00FF);
    check("rdw_after_B", bus.ReadDataB, 16'h0077);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
